alu_muldiv: RTL



---
 rtl/alu_muldiv_pkg.sv | 37 +++
 rtl/muldiv_signfix.sv | 54 +++++
 rtl/alu_muldiv.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_muldiv_pkg                                                     |
// | Shared constants, funct3 codes and FSM encoding for alu_muldiv.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic signed_a(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic signed_b(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_signfix.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | muldiv_signfix                                                     |
// | Operand magnitude conversion and final sign fix / result select.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module muldiv_signfix #(
  parameter int XLEN = alu_muldiv_pkg::XLEN
) (
  input  logic [2:0]        funct3_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  output logic [XLEN-1:0]   a_mag_o,
  output logic [XLEN-1:0]   b_mag_o,
  output logic              res_neg_o,
  output logic              rem_neg_o,
  input  logic [2:0]        f3_i,
  input  logic              neg_i,
  input  logic              rneg_i,
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   quot_i,
  input  logic [XLEN-1:0]   rem_i,
  output logic [XLEN-1:0]   sel_o
);
  import alu_muldiv_pkg::*;

  logic              a_neg;
  logic              b_neg;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  always_comb begin
    a_neg     = signed_a(funct3_i) & op_a_i[XLEN-1];
    b_neg     = signed_b(funct3_i) & op_b_i[XLEN-1];
    a_mag_o   = a_neg ? (~op_a_i + 1'b1) : op_a_i;
    b_mag_o   = b_neg ? (~op_b_i + 1'b1) : op_b_i;
    res_neg_o = a_neg ^ b_neg;
    rem_neg_o = a_neg;

    prod_fix = neg_i  ? (~prod_i + 1'b1) : prod_i;
    quot_fix = neg_i  ? (~quot_i + 1'b1) : quot_i;
    rem_fix  = rneg_i ? (~rem_i  + 1'b1) : rem_i;

    case (f3_i)
      F3_MUL:                       sel_o = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: sel_o = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              sel_o = quot_fix;
      default:                      sel_o = rem_fix;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_muldiv                                                         |
// | Iterative RV32M multiply/divide with start/busy/done handshake.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_muldiv #(
  parameter int XLEN  = alu_muldiv_pkg::XLEN,
  parameter int CNT_W = alu_muldiv_pkg::CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import alu_muldiv_pkg::*;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   opnd_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN:0]     rem_q;
  logic              neg_q;
  logic              rneg_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN-1:0]   result_q;

  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   sel;
  logic              res_neg;
  logic              rem_neg;
  logic              div_zero;
  logic              div_ovf;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] acc_d;
  logic [XLEN:0]     rem_d;

  muldiv_signfix #(.XLEN(XLEN)) u_signfix (
    .funct3_i  (funct3),
    .op_a_i    (op_a),
    .op_b_i    (op_b),
    .a_mag_o   (a_mag),
    .b_mag_o   (b_mag),
    .res_neg_o (res_neg),
    .rem_neg_o (rem_neg),
    .f3_i      (f3_q),
    .neg_i     (neg_q),
    .rneg_i    (rneg_q),
    .prod_i    (acc_q),
    .quot_i    (acc_q[XLEN-1:0]),
    .rem_i     (rem_q[XLEN-1:0]),
    .sel_o     (sel)
  );

  assign div_zero = funct3[2] && (op_b == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  // Multiply keeps the multiplier in acc_q low half and shifts it out LSB first;
  // divide shifts the dividend out of acc_q MSB first while quotient bits enter at bit 0.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
    div_trial = {rem_q, acc_q[XLEN-1]} - {2'b00, opnd_q};
    if (f3_q[2]) begin
      rem_d = div_trial[XLEN+1] ? {rem_q[XLEN-1:0], acc_q[XLEN-1]} : div_trial[XLEN:0];
      acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_trial[XLEN+1]};
    end else begin
      rem_d = rem_q;
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !kill) begin
            f3_q   <= funct3;
            neg_q  <= res_neg;
            rneg_q <= rem_neg;
            cnt_q  <= '0;
            if (div_zero) begin
              result_q <= funct3[1] ? op_a : {XLEN{1'b1}};
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else if (div_ovf) begin
              result_q <= funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              opnd_q  <= funct3[2] ? b_mag : a_mag;
              acc_q   <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
              rem_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_W'(XLEN-1)) begin
              state_q <= S_FIX;
            end
          end
        end
        S_FIX: begin
          busy_q <= 1'b0;
          if (kill) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= sel;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire
